// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM account controller.
package atm_pkg;

    // Session FSM states; the encoding is visible on the state output port.
    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StPinWait   = 4'd1,
        StMenu      = 4'd2,
        StBalance   = 4'd3,
        StWithdraw  = 4'd4,
        StDeposit   = 4'd5,
        StPinChange = 4'd6,
        StError     = 4'd7
    } atm_state_e;

    // Error codes reported on error_code.
    localparam logic [7:0] ErrNone     = 8'h00;
    localparam logic [7:0] ErrBadCard  = 8'h01;
    localparam logic [7:0] ErrBadPin   = 8'h02;
    localparam logic [7:0] ErrLocked   = 8'h03;
    localparam logic [7:0] ErrFunds    = 8'h04;
    localparam logic [7:0] ErrWdLimit  = 8'h05;
    localparam logic [7:0] ErrOverflow = 8'h06;
    localparam logic [7:0] ErrTimeout  = 8'h07;

    // Factory PIN of account idx.
    function automatic logic [31:0] default_pin(input int unsigned idx);
        return 32'h1234 + idx;
    endfunction

endpackage

// File: rtl/atm_timeout_timer.sv
// Inactivity timer: counts enabled, uncleared cycles and flags TIMEOUT_CYC reached.
module atm_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CntW-1:0] r_cnt;
    logic            w_expired;

    assign w_expired = (r_cnt == CntW'(TIMEOUT_CYC));
    assign expired   = w_expired;

    // Count idle cycles, saturating at the timeout value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || !enable) begin
            r_cnt <= '0;
        end else if (!w_expired) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/atm_account_ctrl.sv
// ATM session controller: card/PIN check, per-account balances, withdraw/deposit/PIN change.
module atm_account_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned NUM_CARDS   = 4,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned PIN_W       = 16,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned WD_LIMIT    = 'h0200,
    parameter int unsigned INIT_BAL    = 'h1000,
    localparam int unsigned CW         = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_inserted,
    input  logic [CW-1:0]    card_num,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_input,
    input  logic [PIN_W-1:0] new_pin,
    input  logic             balance_req,
    input  logic             withdrawal_req,
    input  logic             deposit_req,
    input  logic             pin_change_req,
    input  logic             transaction_done,
    input  logic             eject,
    input  logic [BAL_W-1:0] amount,
    output logic [3:0]       state,
    output logic [BAL_W-1:0] balance,
    output logic             transaction_success,
    output logic [7:0]       error_code,
    output logic             card_locked,
    output logic             busy
);

    localparam int unsigned TW         = $clog2(MAX_TRIES + 1);
    localparam logic [BAL_W:0] WdLimit = (BAL_W + 1)'(WD_LIMIT);

    atm_state_e       r_state;
    atm_state_e       r_state_prev;
    logic [CW-1:0]    r_card;
    logic [BAL_W-1:0] r_bal   [NUM_CARDS];
    logic [PIN_W-1:0] r_pin   [NUM_CARDS];
    logic [TW-1:0]    r_tries [NUM_CARDS];
    logic [NUM_CARDS-1:0] r_lock;
    logic [BAL_W-1:0] r_amount;
    logic [BAL_W-1:0] r_sess_total;
    logic [PIN_W-1:0] r_new_pin;
    logic             r_pending;
    logic             r_success;
    logic             r_card_locked;
    logic [7:0]       r_err;

    logic             w_card_ok;
    logic             w_strobe;
    logic             w_tmr_en;
    logic             w_tmr_clear;
    logic             w_expired;
    logic             w_in_session;
    logic [BAL_W-1:0] w_cur_bal;
    logic [BAL_W:0]   w_wd_sum;
    logic [BAL_W:0]   w_dep_sum;
    logic [TW-1:0]    w_try_next;

    assign w_card_ok    = (32'(card_num) < NUM_CARDS);
    assign w_strobe     = card_inserted | pin_valid | balance_req | withdrawal_req |
                          deposit_req | pin_change_req | transaction_done | eject;
    assign w_tmr_en     = (r_state != StIdle) && (r_state != StError);
    assign w_tmr_clear  = w_strobe || (r_state != r_state_prev);
    assign w_in_session = r_state inside {StMenu, StBalance, StWithdraw, StDeposit, StPinChange};
    assign w_cur_bal    = r_bal[r_card];
    // One extra bit so neither sum can wrap before it is checked.
    assign w_wd_sum     = {1'b0, r_sess_total} + {1'b0, r_amount};
    assign w_dep_sum    = {1'b0, w_cur_bal} + {1'b0, r_amount};
    assign w_try_next   = r_tries[r_card] + TW'(1);

    atm_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_tmr_clear),
        .enable (w_tmr_en),
        .expired(w_expired)
    );

    // Session FSM together with account storage and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_state_prev  <= StIdle;
            r_card        <= '0;
            r_lock        <= '0;
            r_amount      <= '0;
            r_sess_total  <= '0;
            r_new_pin     <= '0;
            r_pending     <= 1'b0;
            r_success     <= 1'b0;
            r_card_locked <= 1'b0;
            r_err         <= ErrNone;
            for (int unsigned i = 0; i < NUM_CARDS; i++) begin
                r_bal[i]   <= BAL_W'(INIT_BAL);
                r_pin[i]   <= PIN_W'(default_pin(i));
                r_tries[i] <= '0;
            end
        end else begin
            r_state_prev <= r_state;
            r_success    <= 1'b0;
            if ((r_state != StIdle) && eject) begin
                // Eject abandons the session, including any operation not yet committed.
                r_state      <= StIdle;
                r_pending    <= 1'b0;
                r_sess_total <= '0;
            end else if (w_tmr_en && w_expired) begin
                r_state   <= StError;
                r_err     <= ErrTimeout;
                r_pending <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (card_inserted) begin
                            r_err         <= ErrNone;
                            r_card_locked <= 1'b0;
                            if (!w_card_ok) begin
                                r_state <= StError;
                                r_err   <= ErrBadCard;
                            end else if (r_lock[card_num]) begin
                                r_state       <= StError;
                                r_err         <= ErrLocked;
                                r_card_locked <= 1'b1;
                            end else begin
                                r_state <= StPinWait;
                                r_card  <= card_num;
                            end
                        end
                    end
                    StPinWait: begin
                        if (pin_valid) begin
                            if (pin_input == r_pin[r_card]) begin
                                r_state         <= StMenu;
                                r_tries[r_card] <= '0;
                                r_sess_total    <= '0;
                            end else begin
                                r_tries[r_card] <= w_try_next;
                                if (w_try_next >= TW'(MAX_TRIES)) begin
                                    r_lock[r_card] <= 1'b1;
                                end
                                r_state <= StError;
                                r_err   <= ErrBadPin;
                            end
                        end
                    end
                    StMenu: begin
                        r_amount  <= amount;
                        r_new_pin <= new_pin;
                        if (balance_req) begin
                            r_state   <= StBalance;
                            r_pending <= 1'b1;
                        end else if (withdrawal_req) begin
                            r_state   <= StWithdraw;
                            r_pending <= 1'b1;
                        end else if (deposit_req) begin
                            r_state   <= StDeposit;
                            r_pending <= 1'b1;
                        end else if (pin_change_req) begin
                            r_state   <= StPinChange;
                            r_pending <= 1'b1;
                        end
                    end
                    StBalance, StWithdraw, StDeposit, StPinChange: begin
                        if (r_pending) begin
                            // Operation commits exactly once, on the first cycle in the state.
                            r_pending <= 1'b0;
                            case (r_state)
                                StWithdraw: begin
                                    if ({1'b0, r_amount} > {1'b0, w_cur_bal}) begin
                                        r_err <= ErrFunds;
                                    end else if (w_wd_sum > WdLimit) begin
                                        r_err <= ErrWdLimit;
                                    end else begin
                                        r_bal[r_card] <= w_cur_bal - r_amount;
                                        r_sess_total  <= w_wd_sum[BAL_W-1:0];
                                        r_success     <= 1'b1;
                                    end
                                end
                                StDeposit: begin
                                    if (w_dep_sum[BAL_W]) begin
                                        r_err <= ErrOverflow;
                                    end else begin
                                        r_bal[r_card] <= w_dep_sum[BAL_W-1:0];
                                        r_success     <= 1'b1;
                                    end
                                end
                                StPinChange: begin
                                    r_pin[r_card] <= r_new_pin;
                                    r_success     <= 1'b1;
                                end
                                default: begin
                                    r_success <= 1'b1;
                                end
                            endcase
                        end else if (transaction_done) begin
                            r_state <= StMenu;
                        end
                    end
                    StError: begin
                        r_state   <= StIdle;
                        r_pending <= 1'b0;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign state               = r_state;
    assign balance             = w_in_session ? w_cur_bal : '0;
    assign transaction_success = r_success;
    assign error_code          = r_err;
    assign card_locked         = r_card_locked;
    assign busy                = (r_state != StIdle);

endmodule

// File: tb/tb_atm_account_ctrl.sv
// Directed, table-driven bench for atm_account_ctrl.
module tb_atm_account_ctrl;

    typedef enum int {KNop, KIns, KPin, KBal, KWd, KDep, KChg, KDone, KEject, KBoth} kind_e;

    typedef struct {
        kind_e       kind;
        logic [1:0]  card;
        logic [15:0] data;
        logic [3:0]  st;
        logic [15:0] bal;
        logic        succ;
        logic [7:0]  err;
        logic        lk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_inserted, pin_valid, balance_req, withdrawal_req;
    logic        deposit_req, pin_change_req, transaction_done, eject;
    logic [1:0]  card_num;
    logic [15:0] pin_input, new_pin, amount;

    logic [3:0]  state,   state2;
    logic [15:0] balance, balance2;
    logic        success, success2;
    logic [7:0]  err,     err2;
    logic        lk,      lk2;
    logic        busy,    busy2;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    atm_account_ctrl dut (
        .clk(clk), .rst(rst), .card_inserted(card_inserted), .card_num(card_num),
        .pin_valid(pin_valid), .pin_input(pin_input), .new_pin(new_pin),
        .balance_req(balance_req), .withdrawal_req(withdrawal_req), .deposit_req(deposit_req),
        .pin_change_req(pin_change_req), .transaction_done(transaction_done), .eject(eject),
        .amount(amount), .state(state), .balance(balance), .transaction_success(success),
        .error_code(err), .card_locked(lk), .busy(busy)
    );

    // Three-account instance sharing the stimulus, used for the out-of-range card case.
    atm_account_ctrl #(.NUM_CARDS(3)) dut2 (
        .clk(clk), .rst(rst), .card_inserted(card_inserted), .card_num(card_num),
        .pin_valid(pin_valid), .pin_input(pin_input), .new_pin(new_pin),
        .balance_req(balance_req), .withdrawal_req(withdrawal_req), .deposit_req(deposit_req),
        .pin_change_req(pin_change_req), .transaction_done(transaction_done), .eject(eject),
        .amount(amount), .state(state2), .balance(balance2), .transaction_success(success2),
        .error_code(err2), .card_locked(lk2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic drive(input kind_e k, input logic [1:0] c, input logic [15:0] d);
        card_num  = c;
        pin_input = d;
        amount    = d;
        new_pin   = d;
        case (k)
            KIns:   card_inserted = 1'b1;
            KPin:   pin_valid = 1'b1;
            KBal:   balance_req = 1'b1;
            KWd:    withdrawal_req = 1'b1;
            KDep:   deposit_req = 1'b1;
            KChg:   pin_change_req = 1'b1;
            KDone:  transaction_done = 1'b1;
            KEject: eject = 1'b1;
            KBoth:  begin balance_req = 1'b1; withdrawal_req = 1'b1; end
            default: ;
        endcase
        tick();
        card_inserted = 0; pin_valid = 0; balance_req = 0; withdrawal_req = 0;
        deposit_req = 0; pin_change_req = 0; transaction_done = 0; eject = 0;
    endtask

    task automatic add(input kind_e k, input logic [1:0] c, input logic [15:0] d,
                       input logic [3:0] st, input logic [15:0] b, input logic s,
                       input logic [7:0] e, input logic l);
        vecs.push_back('{k, c, d, st, b, s, e, l});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        card_inserted = 0; pin_valid = 0; balance_req = 0; withdrawal_req = 0;
        deposit_req = 0; pin_change_req = 0; transaction_done = 0; eject = 0;
        card_num = 0; pin_input = 0; new_pin = 0; amount = 0;

        //  kind    card data      st  bal       s  err    lk
        // Card 0: good PIN, withdraw 0x50.
        add(KIns,   0, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   0, 16'h1234, 2, 16'h1000, 0, 8'h00, 0);
        add(KWd,    0, 16'h0050, 4, 16'h1000, 0, 8'h00, 0);
        add(KNop,   0, 16'h0000, 4, 16'h0FB0, 1, 8'h00, 0);
        add(KDone,  0, 16'h0000, 2, 16'h0FB0, 0, 8'h00, 0);
        add(KEject, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0);
        // Card 1: three wrong PINs lock the card.
        add(KIns,   1, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   1, 16'h0000, 7, 16'h0000, 0, 8'h02, 0);
        add(KNop,   1, 16'h0000, 0, 16'h0000, 0, 8'h02, 0);
        add(KIns,   1, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   1, 16'h0000, 7, 16'h0000, 0, 8'h02, 0);
        add(KNop,   1, 16'h0000, 0, 16'h0000, 0, 8'h02, 0);
        add(KIns,   1, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   1, 16'h0000, 7, 16'h0000, 0, 8'h02, 0);
        add(KNop,   1, 16'h0000, 0, 16'h0000, 0, 8'h02, 0);
        add(KIns,   1, 16'h0000, 7, 16'h0000, 0, 8'h03, 1);
        add(KNop,   1, 16'h0000, 0, 16'h0000, 0, 8'h03, 1);
        // Card 2: session withdrawal limit, zero amount, insufficient funds, exact limit.
        add(KIns,   2, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   2, 16'h1236, 2, 16'h1000, 0, 8'h00, 0);
        add(KWd,    2, 16'h0150, 4, 16'h1000, 0, 8'h00, 0);
        add(KNop,   2, 16'h0000, 4, 16'h0EB0, 1, 8'h00, 0);
        add(KDone,  2, 16'h0000, 2, 16'h0EB0, 0, 8'h00, 0);
        add(KWd,    2, 16'h00C0, 4, 16'h0EB0, 0, 8'h00, 0);
        add(KNop,   2, 16'h0000, 4, 16'h0EB0, 0, 8'h05, 0);
        add(KDone,  2, 16'h0000, 2, 16'h0EB0, 0, 8'h05, 0);
        add(KWd,    2, 16'h0000, 4, 16'h0EB0, 0, 8'h05, 0);
        add(KNop,   2, 16'h0000, 4, 16'h0EB0, 1, 8'h05, 0);
        add(KDone,  2, 16'h0000, 2, 16'h0EB0, 0, 8'h05, 0);
        add(KWd,    2, 16'h1000, 4, 16'h0EB0, 0, 8'h05, 0);
        add(KNop,   2, 16'h0000, 4, 16'h0EB0, 0, 8'h04, 0);
        add(KDone,  2, 16'h0000, 2, 16'h0EB0, 0, 8'h04, 0);
        add(KWd,    2, 16'h00B0, 4, 16'h0EB0, 0, 8'h04, 0);
        add(KNop,   2, 16'h0000, 4, 16'h0E00, 1, 8'h04, 0);
        add(KDone,  2, 16'h0000, 2, 16'h0E00, 0, 8'h04, 0);
        add(KEject, 2, 16'h0000, 0, 16'h0000, 0, 8'h04, 0);
        // Card 3: deposit overflow, deposits up to 0xFFFF, balance, priority, PIN change.
        add(KIns,   3, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   3, 16'h1237, 2, 16'h1000, 0, 8'h00, 0);
        add(KDep,   3, 16'hF000, 5, 16'h1000, 0, 8'h00, 0);
        add(KNop,   3, 16'h0000, 5, 16'h1000, 0, 8'h06, 0);
        add(KDone,  3, 16'h0000, 2, 16'h1000, 0, 8'h06, 0);
        add(KDep,   3, 16'h0100, 5, 16'h1000, 0, 8'h06, 0);
        add(KNop,   3, 16'h0000, 5, 16'h1100, 1, 8'h06, 0);
        add(KDone,  3, 16'h0000, 2, 16'h1100, 0, 8'h06, 0);
        add(KDep,   3, 16'hEEFF, 5, 16'h1100, 0, 8'h06, 0);
        add(KNop,   3, 16'h0000, 5, 16'hFFFF, 1, 8'h06, 0);
        add(KDone,  3, 16'h0000, 2, 16'hFFFF, 0, 8'h06, 0);
        add(KBal,   3, 16'h0000, 3, 16'hFFFF, 0, 8'h06, 0);
        add(KNop,   3, 16'h0000, 3, 16'hFFFF, 1, 8'h06, 0);
        add(KDone,  3, 16'h0000, 2, 16'hFFFF, 0, 8'h06, 0);
        add(KBoth,  3, 16'h0010, 3, 16'hFFFF, 0, 8'h06, 0);
        add(KNop,   3, 16'h0000, 3, 16'hFFFF, 1, 8'h06, 0);
        add(KDone,  3, 16'h0000, 2, 16'hFFFF, 0, 8'h06, 0);
        add(KChg,   3, 16'hBEEF, 6, 16'hFFFF, 0, 8'h06, 0);
        add(KNop,   3, 16'h0000, 6, 16'hFFFF, 1, 8'h06, 0);
        add(KDone,  3, 16'h0000, 2, 16'hFFFF, 0, 8'h06, 0);
        add(KEject, 3, 16'h0000, 0, 16'h0000, 0, 8'h06, 0);
        add(KIns,   3, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   3, 16'h1237, 7, 16'h0000, 0, 8'h02, 0);
        add(KNop,   3, 16'h0000, 0, 16'h0000, 0, 8'h02, 0);
        add(KIns,   3, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   3, 16'hBEEF, 2, 16'hFFFF, 0, 8'h00, 0);
        add(KEject, 3, 16'h0000, 0, 16'h0000, 0, 8'h00, 0);
        // Card 0: eject mid-withdraw leaves balance untouched.
        add(KIns,   0, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   0, 16'h1234, 2, 16'h0FB0, 0, 8'h00, 0);
        add(KWd,    0, 16'h0010, 4, 16'h0FB0, 0, 8'h00, 0);
        add(KEject, 0, 16'h0000, 0, 16'h0000, 0, 8'h00, 0);
        add(KIns,   0, 16'h0000, 1, 16'h0000, 0, 8'h00, 0);
        add(KPin,   0, 16'h1234, 2, 16'h0FB0, 0, 8'h00, 0);

        // Reset state.
        tick();
        tick();
        chk("reset state", 32'(state), 32'd0);
        chk("reset balance", 32'(balance), 32'd0);
        chk("reset success", 32'(success), 32'd0);
        chk("reset error_code", 32'(err), 32'd0);
        chk("reset card_locked", 32'(lk), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].kind, vecs[i].card, vecs[i].data);
            chk($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d balance", i), 32'(balance), 32'(vecs[i].bal));
            chk($sformatf("v%0d success", i), 32'(success), 32'(vecs[i].succ));
            chk($sformatf("v%0d error_code", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d card_locked", i), 32'(lk), 32'(vecs[i].lk));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].st != 4'd0));
        end

        // Idle in MENU: no abort well before the timeout, abort with code 07 shortly after.
        repeat (200) tick();
        chk("timeout early state", 32'(state), 32'd2);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (state == 4'd7) found = 1'b1;
        end
        chk("timeout reached", 32'(found), 32'd1);
        chk("timeout error_code", 32'(err), 32'h07);
        tick();
        chk("timeout to idle", 32'(state), 32'd0);

        // Card index beyond NUM_CARDS (three-account instance).
        drive(KIns, 2'd3, 16'h0000);
        chk("bad card state", 32'(state2), 32'd7);
        chk("bad card error_code", 32'(err2), 32'h01);
        chk("bad card busy", 32'(busy2), 32'd1);
        drive(KNop, 2'd3, 16'h0000);
        chk("bad card to idle", 32'(state2), 32'd0);
        drive(KEject, 2'd3, 16'h0000);
        chk("eject main", 32'(state), 32'd0);

        // Reset in the middle of a deposit.
        drive(KIns, 2'd2, 16'h0000);
        drive(KPin, 2'd2, 16'h1236);
        chk("pre-reset balance", 32'(balance), 32'h0E00);
        drive(KDep, 2'd2, 16'h0100);
        chk("deposit entered", 32'(state), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        chk("post-reset success", 32'(success), 32'd0);
        drive(KIns, 2'd2, 16'h0000);
        drive(KPin, 2'd2, 16'h1236);
        chk("post-reset state", 32'(state), 32'd2);
        chk("post-reset balance", 32'(balance), 32'h1000);
        drive(KEject, 2'd2, 16'h0000);
        drive(KIns, 2'd1, 16'h0000);
        chk("lock cleared state", 32'(state), 32'd1);
        chk("lock cleared flag", 32'(lk), 32'd0);
        drive(KEject, 2'd1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
